costas_loop_ctrl: RTL and testbench
===================================

COSTAS_LOOP_CTRL -- requirements
Module: costas_loop_ctrl

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 8: log2 of error-window length in valid samples.
REQ-002 SHALL have parameter LOCK_THRESH, default 24'd262144: window |error| sum below which a window counts as good.
REQ-003 SHALL have parameter UNLOCK_THRESH, default 24'd1048576: window |error| sum above which a window counts as bad.
REQ-004 SHALL have parameter LOCK_COUNT, default 4: consecutive good windows needed to declare lock.
REQ-005 SHALL have parameter UNLOCK_COUNT, default 2: consecutive bad windows needed to declare loss of lock.
REQ-006 SHALL have parameters ACQ_SHIFT, default 4'd2, and TRK_SHIFT, default 4'd6: feedback shift values for acquisition and tracking.
REQ-007 SHALL have parameter FLUSH_CYCLES, default 64: loop-flush duration in clocks.
REQ-008 clk_16M384  in  1  sole clock; all state changes on its rising edge.
REQ-009 rst_16M384  in  1  asynchronous, active-low reset.
REQ-010 enable  in  1  level; 0 forces IDLE.
REQ-011 is_bpsk  in  1  modulation select, also routed to the loop.
REQ-012 error_tdata  in  16  signed phase-error sample from the loop.
REQ-013 error_tvalid  in  1  qualifies error_tdata.
REQ-014 FEEDBACK_SHIFT  out  4  loop-gain shift driven to the NCO wrapper.
REQ-015 loop_rst  out  1  active-high synchronous flush request to the loop datapath.
REQ-016 locked  out  1  carrier-lock flag.
REQ-017 ctrl_state  out  2  current state: 0 IDLE, 1 FLUSH, 2 ACQUIRE, 3 TRACK.

Function
REQ-018 Registered outputs SHALL settle in the cycle after the state transition.
REQ-019 Transitions:
- IDLE -> FLUSH when enable=1.
- FLUSH -> ACQUIRE after FLUSH_CYCLES clocks.
- ACQUIRE -> TRACK after LOCK_COUNT consecutive good windows.
- TRACK -> ACQUIRE after UNLOCK_COUNT consecutive bad windows.
REQ-020 Any change of is_bpsk (registered edge detect) in FLUSH, ACQUIRE or TRACK SHALL enter FLUSH and restart its counter. A change in IDLE SHALL be ignored.
REQ-021 enable=0 SHALL force IDLE on the next clock from any state; this takes priority over the is_bpsk change rule.
REQ-022 Outputs by state:
- loop_rst=1 in IDLE and FLUSH, 0 otherwise.
- locked=1 only in TRACK.
- FEEDBACK_SHIFT=ACQ_SHIFT in IDLE, FLUSH and ACQUIRE.
- FEEDBACK_SHIFT=TRK_SHIFT in TRACK unless REQ-031 applies.
REQ-023 |error| SHALL be computed with saturation: -32768 maps to 32767.
REQ-024 The accumulator SHALL be 16+WIN_LOG2 bits, unsigned, add only on error_tvalid, and never wrap.
REQ-025 On the 2^WIN_LOG2-th valid sample the window SHALL close:
- The sum includes that sample.
- The sum is compared against the thresholds.
- The accumulator reloads to 0 in the same cycle.
REQ-026 A sum exactly equal to LOCK_THRESH SHALL count as not good. A sum exactly equal to UNLOCK_THRESH SHALL count as not bad.
REQ-027 A non-good window SHALL clear the good counter. A non-bad window SHALL clear the bad counter. Both counters saturate at their targets.
REQ-028 The accumulator and both counters SHALL clear on entry to FLUSH and in IDLE. Samples arriving during FLUSH SHALL be discarded.
REQ-029 Entering ACQUIRE or TRACK SHALL clear both counters, so every window decision starts clean.

Reset
REQ-030 While rst_16M384=0 the block SHALL hold:
- ctrl_state=IDLE, loop_rst=1, locked=0, FEEDBACK_SHIFT=ACQ_SHIFT.
- Accumulator, counters and the is_bpsk history register all 0.
Reset release requires no synchronizer inside the block.

Configuration
REQ-031 With COSTAS_CTRL_GEARSHIFT_EN defined, TRACK SHALL ramp FEEDBACK_SHIFT instead of jumping:
- Entry value is ACQ_SHIFT+1.
- Each good window adds 1, up to TRK_SHIFT.
- Any bad window returns it to ACQ_SHIFT+1.
- Leaving TRACK restores ACQ_SHIFT.
REQ-032 Without COSTAS_CTRL_GEARSHIFT_EN, FEEDBACK_SHIFT SHALL step directly to TRK_SHIFT on entry to TRACK, and the ramp logic SHALL be absent.

Structure
REQ-033 The state encoding localparams and the default shift constants SHALL live in the shared package costas_pkg.
REQ-034 Window accumulation and threshold classification SHALL be the sub-module err_window_meter. It outputs one-cycle strobes win_done, win_good and win_bad.
REQ-035 The FSM, counters and output registers SHALL reside in costas_loop_ctrl.

Verification
REQ-036 Reset, then enable=1 -> loop_rst=1 for 64 clocks, then ctrl_state=2, FEEDBACK_SHIFT=2.
REQ-037 ACQUIRE with a constant error of 100 at every valid -> sum 25600 per window. After 4 windows: locked=1, ctrl_state=3, FEEDBACK_SHIFT=6 (gear-shift: 3 -> 4 -> 5 -> 6 on subsequent good windows).
REQ-038 TRACK, then constant error -32768 -> abs saturates to 32767, sum 8388352. After 2 windows: locked=0, ctrl_state=2.
REQ-039 is_bpsk toggled mid-window in TRACK -> FLUSH next cycle, locked=0, partial accumulator discarded, 64-clock flush restarted.
REQ-040 rst_16M384 asserted mid-window in ACQUIRE -> all outputs take their REQ-030 values immediately, without waiting for a clock edge.
REQ-041 Boundary: window sum exactly 262144 -> good counter clears, no lock declared.

Source files
------------

// File: rtl/costas_pkg.sv
// Shared definitions for the Costas loop lock controller:
// state encoding, default loop-gain shifts and a saturating |x| helper.
package costas_pkg;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_FLUSH   = 2'd1;
    localparam logic [1:0] STATE_ACQUIRE = 2'd2;
    localparam logic [1:0] STATE_TRACK   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = STATE_IDLE,
        ST_FLUSH   = STATE_FLUSH,
        ST_ACQUIRE = STATE_ACQUIRE,
        ST_TRACK   = STATE_TRACK
    } ctrl_state_e;

    localparam logic [3:0] ACQ_SHIFT_DEFAULT = 4'd2;
    localparam logic [3:0] TRK_SHIFT_DEFAULT = 4'd6;

    // -32768 has no positive counterpart in 16 bits, so it clips to 32767
    function automatic logic [15:0] abs_sat(input logic signed [15:0] x);
        logic [15:0] r;
        if (x == 16'sh8000) begin
            r = 16'h7FFF;
        end else if (x < 0) begin
            r = 16'(-x);
        end else begin
            r = 16'(x);
        end
        return r;
    endfunction

endpackage

// File: rtl/err_window_meter.sv
// Sums saturated |error| over 2^WIN_LOG2 valid samples and classifies each
// closed window against the lock/unlock thresholds with one-cycle strobes.
module err_window_meter
    import costas_pkg::*;
#(
    parameter int          WIN_LOG2      = 8,
    parameter logic [23:0] LOCK_THRESH   = 24'd262144,
    parameter logic [23:0] UNLOCK_THRESH = 24'd1048576
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic signed [15:0] data_i,
    input  logic               valid_i,
    output logic               win_done,
    output logic               win_good,
    output logic               win_bad
);

    localparam int AW  = 16 + WIN_LOG2;
    localparam int AW1 = AW + 1;
    localparam int CW  = (AW > 24) ? AW : 24;

    logic [AW-1:0]       acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                good_q, good_d;
    logic                bad_q, bad_d;
    logic [AW:0]         sum_wide;
    logic [AW-1:0]       sum;
    logic [CW-1:0]       sum_cmp;

    // The sum cannot exceed the accumulator range by construction; the clip is a guard
    assign sum_wide = {1'b0, acc_q} + AW1'(abs_sat(data_i));
    assign sum      = sum_wide[AW] ? '1 : sum_wide[AW-1:0];
    assign sum_cmp  = CW'(sum);

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        good_d = 1'b0;
        bad_d  = 1'b0;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (valid_i) begin
            if (&cnt_q) begin
                acc_d  = '0;
                cnt_d  = '0;
                done_d = 1'b1;
                good_d = (sum_cmp < CW'(LOCK_THRESH));
                bad_d  = (sum_cmp > CW'(UNLOCK_THRESH));
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + WIN_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            good_q <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign win_done = done_q;
    assign win_good = good_q;
    assign win_bad  = bad_q;

endmodule

// File: rtl/costas_loop_ctrl.sv
// Costas loop lock controller: IDLE/FLUSH/ACQUIRE/TRACK sequencing and loop-gain selection.
// Define COSTAS_CTRL_GEARSHIFT_EN to ramp the tracking shift up one step per good window.
module costas_loop_ctrl
    import costas_pkg::*;
#(
    parameter int          WIN_LOG2      = 8,
    parameter logic [23:0] LOCK_THRESH   = 24'd262144,
    parameter logic [23:0] UNLOCK_THRESH = 24'd1048576,
    parameter int          LOCK_COUNT    = 4,
    parameter int          UNLOCK_COUNT  = 2,
    parameter logic [3:0]  ACQ_SHIFT     = ACQ_SHIFT_DEFAULT,
    parameter logic [3:0]  TRK_SHIFT     = TRK_SHIFT_DEFAULT,
    parameter int          FLUSH_CYCLES  = 64
) (
    input  logic               clk_16M384,
    input  logic               rst_16M384,
    input  logic               enable,
    input  logic               is_bpsk,
    input  logic signed [15:0] error_tdata,
    input  logic               error_tvalid,
    output logic [3:0]         FEEDBACK_SHIFT,
    output logic               loop_rst,
    output logic               locked,
    output logic [1:0]         ctrl_state
);

    localparam int GCW = $clog2(LOCK_COUNT + 1);
    localparam int BCW = $clog2(UNLOCK_COUNT + 1);
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    ctrl_state_e    state_q, state_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic [GCW-1:0] good_cnt_q, good_cnt_d, good_next;
    logic [BCW-1:0] bad_cnt_q, bad_cnt_d, bad_next;
    logic [3:0]     shift_q, shift_d;
    logic           bpsk_q;
    logic           loop_rst_q, locked_q;
    logic           mode_change;
    logic           meter_clear;
    logic           win_done, win_good, win_bad;

    assign mode_change = is_bpsk ^ bpsk_q;
    assign meter_clear = (state_q == ST_IDLE) || (state_q == ST_FLUSH) ||
                         (state_d == ST_IDLE) || (state_d == ST_FLUSH);

    err_window_meter #(
        .WIN_LOG2      (WIN_LOG2),
        .LOCK_THRESH   (LOCK_THRESH),
        .UNLOCK_THRESH (UNLOCK_THRESH)
    ) u_meter (
        .clk_i    (clk_16M384),
        .rst_ni   (rst_16M384),
        .clear_i  (meter_clear),
        .data_i   (error_tdata),
        .valid_i  (error_tvalid),
        .win_done (win_done),
        .win_good (win_good),
        .win_bad  (win_bad)
    );

    assign good_next = !win_good ? '0 :
                       (good_cnt_q == GCW'(LOCK_COUNT)) ? good_cnt_q : good_cnt_q + GCW'(1);
    assign bad_next  = !win_bad ? '0 :
                       (bad_cnt_q == BCW'(UNLOCK_COUNT)) ? bad_cnt_q : bad_cnt_q + BCW'(1);

    // Disable beats a modulation change, which beats the normal sequencing
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE || mode_change) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (flush_cnt_q == FCW'(FLUSH_CYCLES - 1)) begin
                        state_d = ST_ACQUIRE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FCW'(1);
                    end
                end
                ST_ACQUIRE: begin
                    if (win_done) begin
                        good_cnt_d = good_next;
                        bad_cnt_d  = bad_next;
                        if (good_next == GCW'(LOCK_COUNT)) begin
                            state_d    = ST_TRACK;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end
                    end
                end
                ST_TRACK: begin
                    if (win_done) begin
                        good_cnt_d = good_next;
                        bad_cnt_d  = bad_next;
                        if (bad_next == BCW'(UNLOCK_COUNT)) begin
                            state_d    = ST_ACQUIRE;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        if (state_d == ST_IDLE || state_d == ST_FLUSH) begin
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end
    end

`ifdef COSTAS_CTRL_GEARSHIFT_EN
    always_comb begin
        shift_d = ACQ_SHIFT;
        if (state_d == ST_TRACK) begin
            if (state_q != ST_TRACK) begin
                shift_d = ACQ_SHIFT + 4'd1;
            end else if (win_done && win_bad) begin
                shift_d = ACQ_SHIFT + 4'd1;
            end else if (win_done && win_good && (shift_q < TRK_SHIFT)) begin
                shift_d = shift_q + 4'd1;
            end else begin
                shift_d = shift_q;
            end
        end
    end
`else
    always_comb begin
        shift_d = (state_d == ST_TRACK) ? TRK_SHIFT : ACQ_SHIFT;
    end
`endif

    // Outputs are registered from the next state so they line up with ctrl_state
    always_ff @(posedge clk_16M384 or negedge rst_16M384) begin
        if (!rst_16M384) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            bpsk_q      <= 1'b0;
            shift_q     <= ACQ_SHIFT;
            loop_rst_q  <= 1'b1;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            bpsk_q      <= is_bpsk;
            shift_q     <= shift_d;
            loop_rst_q  <= (state_d == ST_IDLE) || (state_d == ST_FLUSH);
            locked_q    <= (state_d == ST_TRACK);
        end
    end

    assign ctrl_state     = state_q;
    assign FEEDBACK_SHIFT = shift_q;
    assign loop_rst       = loop_rst_q;
    assign locked         = locked_q;

endmodule

// File: tb/tb_costas_loop_ctrl.sv
// Self-checking bench for costas_loop_ctrl: directed lock/unlock scenarios followed by
// randomized error traffic, all compared against a window-level reference model.
module tb_costas_loop_ctrl;

    localparam int WIN     = 256;
    localparam int LOCKT   = 262144;
    localparam int UNLOCKT = 1048576;
    localparam int LOCKN   = 4;
    localparam int UNLOCKN = 2;
    localparam int ACQS    = 2;
    localparam int TRKS    = 6;
    localparam int FLUSHN  = 64;
`ifdef COSTAS_CTRL_GEARSHIFT_EN
    localparam int TRK_ENTRY_SHIFT = ACQS + 1;
`else
    localparam int TRK_ENTRY_SHIFT = TRKS;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic               is_bpsk = 1'b0;
    logic signed [15:0] err = '0;
    logic               vld = 1'b0;
    logic [3:0]         shift;
    logic               loop_rst;
    logic               locked;
    logic [1:0]         ctrl_state;

    int checks = 0;
    int failures = 0;

    int    mState, mFlushLeft, mSamples, mGoodRun, mBadRun, mShift;
    longint mSum;
    bit    mPrevBpsk, mPend, mPendGood, mPendBad;

    costas_loop_ctrl #(
        .WIN_LOG2      (8),
        .LOCK_THRESH   (24'd262144),
        .UNLOCK_THRESH (24'd1048576),
        .LOCK_COUNT    (LOCKN),
        .UNLOCK_COUNT  (UNLOCKN),
        .ACQ_SHIFT     (4'd2),
        .TRK_SHIFT     (4'd6),
        .FLUSH_CYCLES  (FLUSHN)
    ) dut (
        .clk_16M384     (clk),
        .rst_16M384     (rst_n),
        .enable         (enable),
        .is_bpsk        (is_bpsk),
        .error_tdata    (err),
        .error_tvalid   (vld),
        .FEEDBACK_SHIFT (shift),
        .loop_rst       (loop_rst),
        .locked         (locked),
        .ctrl_state     (ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int absSat(input int e);
        if (e == -32768) return 32767;
        return (e < 0) ? -e : e;
    endfunction

    task automatic modelReset();
        mState = 0; mFlushLeft = 0; mSamples = 0; mSum = 0;
        mGoodRun = 0; mBadRun = 0; mShift = ACQS;
        mPrevBpsk = 0; mPend = 0; mPendGood = 0; mPendBad = 0;
    endtask

    // One clock of the reference: a window verdict is acted on one clock after it closes
    task automatic modelStep(input bit en, input bit bp, input int e, input bit v);
        int ns;
        bit decided, good, bad;
        ns = mState; decided = mPend; good = mPendGood; bad = mPendBad;
        if (!en) begin
            ns = 0;
        end else if (mState == 0 || bp != mPrevBpsk) begin
            ns = 1;
            mFlushLeft = FLUSHN;
        end else if (mState == 1) begin
            mFlushLeft--;
            if (mFlushLeft == 0) ns = 2;
        end else if (decided) begin
            mGoodRun = good ? ((mGoodRun < LOCKN) ? mGoodRun + 1 : LOCKN) : 0;
            mBadRun  = bad ? ((mBadRun < UNLOCKN) ? mBadRun + 1 : UNLOCKN) : 0;
            if (mState == 2 && mGoodRun == LOCKN) ns = 3;
            if (mState == 3 && mBadRun == UNLOCKN) ns = 2;
            if (ns != mState) begin mGoodRun = 0; mBadRun = 0; end
        end
        if (ns == 3) begin
`ifdef COSTAS_CTRL_GEARSHIFT_EN
            if (mState != 3) mShift = ACQS + 1;
            else if (decided && bad) mShift = ACQS + 1;
            else if (decided && good && mShift < TRKS) mShift = mShift + 1;
`else
            mShift = TRKS;
`endif
        end else begin
            mShift = ACQS;
        end
        mPend = 0;
        if (mState <= 1 || ns <= 1) begin
            mSum = 0; mSamples = 0; mGoodRun = 0; mBadRun = 0;
        end else if (v) begin
            mSum += absSat(e);
            mSamples++;
            if (mSamples == WIN) begin
                mPend = 1;
                mPendGood = (mSum < LOCKT);
                mPendBad  = (mSum > UNLOCKT);
                mSum = 0;
                mSamples = 0;
            end
        end
        mPrevBpsk = bp;
        mState = ns;
    endtask

    task automatic applyStimulus(input bit en, input bit bp, input int e, input bit v);
        enable = en; is_bpsk = bp; err = e[15:0]; vld = v;
        @(posedge clk);
        modelStep(en, bp, e, v);
        @(negedge clk);
        checkOutput("ctrl_state", 32'(ctrl_state), 32'(mState));
        checkOutput("loop_rst", 32'(loop_rst), (mState <= 1) ? 32'd1 : 32'd0);
        checkOutput("locked", 32'(locked), (mState == 3) ? 32'd1 : 32'd0);
        checkOutput("feedback_shift", 32'(shift), 32'(mShift));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, 32'(ctrl_state), 32'd0);
        checkOutput({tag, "_loop_rst"}, 32'(loop_rst), 32'd1);
        checkOutput({tag, "_locked"}, 32'(locked), 32'd0);
        checkOutput({tag, "_shift"}, 32'(shift), 32'(ACQS));
    endtask

    task automatic countFlush(input bit bp, input string tag);
        int n;
        n = 0;
        while (ctrl_state == 2'd1 && n < 200) begin
            n++;
            applyStimulus(1, bp, 100, 1);
        end
        checkOutput(tag, 32'(n), 32'(FLUSHN));
    endtask

    initial begin
        bit curEn, curBpsk;
        modelReset();
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        repeat (3) applyStimulus(0, 0, 0, 0);

        // Enable: flush for FLUSH_CYCLES, then acquisition gain
        applyStimulus(1, 0, 100, 1);
        countFlush(0, "flush_len");
        checkOutput("acq_state", 32'(ctrl_state), 32'd2);
        checkOutput("acq_shift", 32'(shift), 32'(ACQS));

        // Constant error 100 -> four good windows -> lock
        repeat (1030) applyStimulus(1, 0, 100, 1);
        checkOutput("lock_state", 32'(ctrl_state), 32'd3);
        checkOutput("lock_flag", 32'(locked), 32'd1);
        checkOutput("lock_entry_shift", 32'(shift), 32'(TRK_ENTRY_SHIFT));
        repeat (770) applyStimulus(1, 0, 100, 1);
        checkOutput("track_shift", 32'(shift), 32'(TRKS));

        // Modulation change mid-window in TRACK
        applyStimulus(1, 1, 100, 1);
        checkOutput("toggle_state", 32'(ctrl_state), 32'd1);
        checkOutput("toggle_locked", 32'(locked), 32'd0);
        countFlush(1, "reflush_len");

        // Boundary window sum == LOCK_THRESH breaks the good run
        repeat (512) applyStimulus(1, 1, 100, 1);
        repeat (256) applyStimulus(1, 1, 1024, 1);
        repeat (520) applyStimulus(1, 1, 100, 1);
        checkOutput("boundary_state", 32'(ctrl_state), 32'd2);
        checkOutput("boundary_locked", 32'(locked), 32'd0);
        repeat (520) applyStimulus(1, 1, 100, 1);
        checkOutput("relock_state", 32'(ctrl_state), 32'd3);

        // Saturated -32768 errors -> two bad windows -> unlock
        repeat (600) applyStimulus(1, 1, -32768, 1);
        checkOutput("unlock_state", 32'(ctrl_state), 32'd2);
        checkOutput("unlock_locked", 32'(locked), 32'd0);
        checkOutput("unlock_shift", 32'(shift), 32'(ACQS));

        // Asynchronous reset mid-window, between clock edges
        repeat (100) applyStimulus(1, 1, 100, 1);
        #2 rst_n = 1'b0;
        #1 checkResetValues("async_reset");
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with occasional disables and modulation changes
        curEn = 1; curBpsk = 1;
        for (int s = 0; s < 10; s++) begin
            int kind, len;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(300, 1500);
            for (int i = 0; i < len; i++) begin
                int mag, e;
                bit v;
                if (kind <= 3)      mag = $urandom_range(0, 900);
                else if (kind == 4) mag = 1024;
                else if (kind == 5) mag = 4096;
                else if (kind <= 7) mag = $urandom_range(4200, 32767);
                else if (kind == 8) mag = $urandom_range(900, 4500);
                else                mag = 32768;
                e = ($urandom_range(0, 1) == 1 || mag == 32768) ? -mag : mag;
                if (e == 32768) e = 32767;
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 599) == 0) curBpsk = ~curBpsk;
                if ($urandom_range(0, 999) == 0) curEn = 0;
                else if (!curEn && $urandom_range(0, 9) == 0) curEn = 1;
                applyStimulus(curEn, curBpsk, e, v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
